// File: rtl/calc_op_sequencer_if.sv
// ALU handshake bundle between the calculator sequencer (master) and the
// shared multi-cycle arithmetic unit (slave).
interface calc_op_sequencer_if #(parameter int W = 11);
  logic         alu_start;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_abort;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_overflow;

  modport master (
    output alu_start, alu_op, alu_a, alu_b, alu_abort,
    input  alu_done, alu_result, alu_overflow
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b, alu_abort,
    output alu_done, alu_result, alu_overflow
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Calculator control sequencer: edge-detects panel buttons, owns accumulator,
// pending operator and error state, and issues single ALU transactions.
//
// state      | meaning
// S_ENTRY    | waiting for first operand (Equals loads Acc)
// S_WAIT_OP  | Acc valid, waiting for an operator
// S_WAIT_NUM | operator pending, Equals loads operand and issues
// S_ISSUE    | one cycle: AluStart, or divide-by-zero error
// S_EXEC     | waiting for AluDone, bounded by timeout
// S_ERROR    | sticky error until Clear
module calc_op_sequencer #(
  parameter int W       = 11,
  parameter int TIMEOUT = 64
) (
  input  logic                clock_i,
  input  logic                clear_n_i,
  input  logic                clear_i,
  input  logic                equals_i,
  input  logic                add_i,
  input  logic                subtract_i,
  input  logic                multiply_i,
  input  logic                divide_i,
  input  logic [W-1:0]        number_sm_i,
  calc_op_sequencer_if.master alu,
  output logic [W-1:0]        result_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam logic [2:0] S_ENTRY    = 3'd0;
  localparam logic [2:0] S_WAIT_OP  = 3'd1;
  localparam logic [2:0] S_WAIT_NUM = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [1:0]    pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    btn_prev_q;

  logic [5:0]   btn_lvl;
  logic [5:0]   btn_press;
  logic         clr_press, eq_press, op_press;
  logic [1:0]   op_sel;
  logic [W-1:0] mag_ext, number_tc;
  logic         div_zero;
  logic         start, abort;

  assign btn_lvl   = {clear_i, equals_i, add_i, subtract_i, multiply_i, divide_i};
  assign btn_press = btn_lvl & ~btn_prev_q;
  assign clr_press = btn_press[5];
  assign eq_press  = btn_press[4];
  assign op_press  = |btn_press[3:0];

  always_comb begin
    op_sel = OP_DIV;
    if (btn_press[3])      op_sel = OP_ADD;
    else if (btn_press[2]) op_sel = OP_SUB;
    else if (btn_press[1]) op_sel = OP_MUL;
  end

  // Negative zero folds to zero naturally since 0 - 0 = 0.
  assign mag_ext   = {1'b0, number_sm_i[W-2:0]};
  assign number_tc = number_sm_i[W-1] ? ({W{1'b0}} - mag_ext) : mag_ext;
  assign div_zero  = (pend_q == OP_DIV) && (opnd_q == '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    start   = 1'b0;
    abort   = 1'b0;
    if (clr_press) begin
      state_d = S_ENTRY;
      acc_d   = '0;
      opnd_d  = '0;
      pend_d  = OP_ADD;
      timer_d = '0;
      abort   = (state_q == S_EXEC);
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (eq_press) begin
            acc_d   = number_tc;
            state_d = S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (eq_press) begin
            acc_d = number_tc;
          end else if (op_press) begin
            pend_d  = op_sel;
            state_d = S_WAIT_NUM;
          end
        end
        S_WAIT_NUM: begin
          if (eq_press) begin
            opnd_d  = number_tc;
            state_d = S_ISSUE;
          end else if (op_press) begin
            pend_d = op_sel;
          end
        end
        S_ISSUE: begin
          if (div_zero) begin
            state_d = S_ERROR;
          end else begin
            start   = 1'b1;
            timer_d = TIMER_LOAD;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          // Down-counter loaded with TIMEOUT-1: terminal count hits on the
          // TIMEOUT-th EXEC cycle, and a late AluDone in that cycle still wins.
          if (alu.alu_done) begin
            if (alu.alu_overflow) begin
              state_d = S_ERROR;
            end else begin
              acc_d   = alu.alu_result;
              state_d = S_WAIT_OP;
            end
          end else if (timer_q == '0) begin
            abort   = 1'b1;
            state_d = S_ERROR;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        S_ERROR: ;
        default: state_d = S_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q    <= S_ENTRY;
      acc_q      <= '0;
      opnd_q     <= '0;
      pend_q     <= OP_ADD;
      timer_q    <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      pend_q     <= pend_d;
      timer_q    <= timer_d;
      btn_prev_q <= btn_lvl;
    end
  end

  assign alu.alu_start = start;
  assign alu.alu_abort = abort;
  assign alu.alu_op    = pend_q;
  assign alu.alu_a     = acc_q;
  assign alu.alu_b     = opnd_q;
  assign result_o      = acc_q;
  assign overflow_o    = (state_q == S_ERROR);
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_EXEC);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a behavioural multi-cycle ALU.
module tb_calc_op_sequencer;
  localparam int W       = 11;
  localparam int TIMEOUT = 64;

  localparam logic [5:0] M_CLR = 6'b100000;
  localparam logic [5:0] M_EQ  = 6'b010000;
  localparam logic [5:0] M_ADD = 6'b001000;
  localparam logic [5:0] M_SUB = 6'b000100;
  localparam logic [5:0] M_MUL = 6'b000010;
  localparam logic [5:0] M_DIV = 6'b000001;

  typedef struct {
    logic [W-1:0] a_sm;
    logic [5:0]   op_btn;
    logic [W-1:0] b_sm;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
    int           exp_starts;
    logic [1:0]   exp_op;
    logic [W-1:0] exp_b;
  } vec_t;

  logic         clock = 1'b0;
  logic         clear_n;
  logic [5:0]   btn;
  logic [W-1:0] num_sm;
  logic [W-1:0] result;
  logic         overflow, busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  logic [1:0]   cap_op;
  logic [W-1:0] cap_a, cap_b;
  logic mute = 1'b0;
  logic spur_req = 1'b0;

  calc_op_sequencer_if #(.W(W)) alu_if();

  calc_op_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock_i     (clock),
    .clear_n_i   (clear_n),
    .clear_i     (btn[5]),
    .equals_i    (btn[4]),
    .add_i       (btn[3]),
    .subtract_i  (btn[2]),
    .multiply_i  (btn[1]),
    .divide_i    (btn[0]),
    .number_sm_i (num_sm),
    .alu         (alu_if.master),
    .result_o    (result),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  always #5 clock = ~clock;

  function automatic void alu_model(input logic [1:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] r,
                                    output logic ovf);
    int ai, bi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    case (op)
      2'b00:   ri = ai + bi;
      2'b01:   ri = ai - bi;
      2'b10:   ri = ai * bi;
      default: ri = (bi == 0) ? 0 : ai / bi;
    endcase
    ovf = (ri > 1023) || (ri < -1024);
    r   = ri[W-1:0];
  endfunction

  // ALU model and abort monitor, sampling 3 time units after each falling edge.
  initial begin
    logic [W-1:0] r;
    logic         o;
    alu_if.alu_done     = 1'b0;
    alu_if.alu_result   = '0;
    alu_if.alu_overflow = 1'b0;
    forever begin
      @(negedge clock); #3;
      alu_if.alu_done = 1'b0;
      if (alu_if.alu_abort) abort_cnt++;
      if (spur_req) begin
        alu_if.alu_done     = 1'b1;
        alu_if.alu_result   = 11'd555;
        alu_if.alu_overflow = 1'b0;
      end
      if (alu_if.alu_start) begin
        start_cnt++;
        cap_op = alu_if.alu_op;
        cap_a  = alu_if.alu_a;
        cap_b  = alu_if.alu_b;
        if (!mute) begin
          alu_model(cap_op, cap_a, cap_b, r, o);
          repeat (2) begin
            @(negedge clock); #3;
            if (alu_if.alu_abort) abort_cnt++;
          end
          alu_if.alu_done     = 1'b1;
          alu_if.alu_result   = r;
          alu_if.alu_overflow = o;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic press(input logic [5:0] m, input logic [W-1:0] n);
    btn    = m;
    num_sm = n;
    tick();
    btn = '0;
    tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int s0, a0, cnt;

    vecs[0] = '{11'd1,    M_ADD, 11'd2,    11'd3,    1'b0, 1, 2'd0, 11'd2};
    vecs[1] = '{11'h3FF,  M_ADD, 11'd10,   11'h3FF,  1'b1, 1, 2'd0, 11'd10};
    vecs[2] = '{11'd5,    M_SUB, 11'h403,  11'd8,    1'b0, 1, 2'd1, 11'h7FD};
    vecs[3] = '{11'd7,    M_MUL, 11'd6,    11'd42,   1'b0, 1, 2'd2, 11'd6};
    vecs[4] = '{11'd100,  M_DIV, 11'd7,    11'd14,   1'b0, 1, 2'd3, 11'd7};
    vecs[5] = '{11'h414,  M_DIV, 11'd3,    11'h7FA,  1'b0, 1, 2'd3, 11'd3};
    vecs[6] = '{11'd3,    M_DIV, 11'h400,  11'd3,    1'b1, 0, 2'd3, 11'd0};
    vecs[7] = '{11'd0,    M_ADD, 11'h7FF,  11'h401,  1'b0, 1, 2'd0, 11'h401};
    vecs[8] = '{11'd40,   M_MUL, 11'd40,   11'd40,   1'b1, 1, 2'd2, 11'd40};

    btn     = '0;
    num_sm  = '0;
    clear_n = 1'b0;
    repeat (3) tick();
    chk("reset result",    int'(result), 0);
    chk("reset overflow",  int'(overflow), 0);
    chk("reset busy",      int'(busy), 0);
    chk("reset alu_start", int'(alu_if.alu_start), 0);
    chk("reset alu_abort", int'(alu_if.alu_abort), 0);
    chk("reset alu_op",    int'(alu_if.alu_op), 0);
    chk("reset alu_a",     int'(alu_if.alu_a), 0);
    chk("reset alu_b",     int'(alu_if.alu_b), 0);
    clear_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      press(M_CLR, '0);
      press(M_EQ, vecs[i].a_sm);
      press(vecs[i].op_btn, '0);
      s0 = start_cnt;
      press(M_EQ, vecs[i].b_sm);
      wait_idle($sformatf("v%0d idle", i));
      chk($sformatf("v%0d result", i),   int'(result),   int'(vecs[i].exp_res));
      chk($sformatf("v%0d overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
      chk($sformatf("v%0d starts", i),   start_cnt - s0, vecs[i].exp_starts);
      if (vecs[i].exp_starts == 1) begin
        chk($sformatf("v%0d alu_op", i), int'(cap_op), int'(vecs[i].exp_op));
        chk($sformatf("v%0d alu_b", i),  int'(cap_b),  int'(vecs[i].exp_b));
      end
    end

    // Chained 1 + 3 - 4: second transaction operates on the running result.
    press(M_CLR, '0);
    press(M_EQ, 11'd1);
    press(M_ADD, '0);
    press(M_EQ, 11'd3);
    wait_idle("chain first idle");
    chk("chain first result", int'(result), 4);
    press(M_SUB, '0);
    press(M_EQ, 11'd4);
    wait_idle("chain second idle");
    chk("chain alu_a",  int'(cap_a), 4);
    chk("chain alu_op", int'(cap_op), 1);
    chk("chain alu_b",  int'(cap_b), 4);
    chk("chain result", int'(result), 0);

    // Error is sticky: further presses ignored until Clear.
    press(M_CLR, '0);
    press(M_EQ, 11'h3FF);
    press(M_ADD, '0);
    press(M_EQ, 11'd10);
    wait_idle("sticky idle");
    s0 = start_cnt;
    press(M_ADD, '0);
    press(M_EQ, 11'd5);
    repeat (3) tick();
    chk("sticky starts",   start_cnt - s0, 0);
    chk("sticky result",   int'(result), 1023);
    chk("sticky overflow", int'(overflow), 1);
    press(M_CLR, '0);
    chk("cleared result",   int'(result), 0);
    chk("cleared overflow", int'(overflow), 0);

    // Held buttons fire once; Add+Multiply together resolves to Add.
    press(M_CLR, '0);
    press(M_EQ, 11'd1);
    btn = M_ADD;
    repeat (20) tick();
    btn = '0;
    tick();
    s0 = start_cnt;
    num_sm = 11'd2;
    btn = M_EQ;
    repeat (20) tick();
    btn = '0;
    tick();
    wait_idle("held idle");
    chk("held starts", start_cnt - s0, 1);
    chk("held result", int'(result), 3);
    press(M_ADD | M_MUL, '0);
    press(M_EQ, 11'd3);
    wait_idle("prio idle");
    chk("prio alu_op", int'(cap_op), 0);
    chk("prio result", int'(result), 6);

    // AluDone outside EXEC must not touch the accumulator.
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    repeat (2) tick();
    chk("spurious done result", int'(result), 6);

    // Equals with an operator in the same cycle: reload wins, operator dropped.
    s0 = start_cnt;
    press(M_EQ | M_SUB, 11'd9);
    chk("eq+op reload", int'(result), 9);
    press(M_EQ, 11'd2);
    chk("eq+op no issue starts", start_cnt - s0, 0);
    chk("eq+op second reload", int'(result), 2);

    // Clear while the ALU never answers.
    mute = 1'b1;
    press(M_CLR, '0);
    press(M_EQ, 11'd1);
    press(M_ADD, '0);
    press(M_EQ, 11'd2);
    repeat (5) tick();
    chk("midexec busy", int'(busy), 1);
    a0 = abort_cnt;
    press(M_CLR, '0);
    chk("midexec aborts",   abort_cnt - a0, 1);
    chk("midexec busy off", int'(busy), 0);
    chk("midexec result",   int'(result), 0);

    // Timeout: overflow appears after the Equals edge + ISSUE + 64 EXEC cycles.
    press(M_EQ, 11'd1);
    press(M_ADD, '0);
    a0 = abort_cnt;
    press(M_EQ, 11'd2);
    cnt = 0;
    while (!overflow && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("timeout cycles",   cnt, TIMEOUT);
    chk("timeout aborts",   abort_cnt - a0, 1);
    chk("timeout overflow", int'(overflow), 1);
    chk("timeout result",   int'(result), 1);
    chk("timeout busy",     int'(busy), 0);
    mute = 1'b0;
    press(M_CLR, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
